// File: rtl/serie_universal_shifter.sv
// WIDTH-bit universal shift register: shift/rotate/load per cycle, plus a counted
// burst of shift or rotate steps with a busy flag and a one-cycle done pulse.
module serie_universal_shifter #(
    parameter int unsigned            WIDTH     = 8,
    parameter logic [WIDTH-1:0]       RESET_VAL = '0,
    localparam int unsigned           CNT_W     = $clog2(WIDTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [1:0]       mode,
    input  logic             leftright,
    input  logic             serial_in,
    input  logic [WIDTH-1:0] par_in,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    output logic             serial_out,
    output logic [WIDTH-1:0] par_out,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] MODE_SHIFT  = 2'b01;
    localparam logic [1:0] MODE_ROTATE = 2'b10;
    localparam logic [1:0] MODE_LOAD   = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_q;
    logic               r_rot;
    logic               r_dir;
    logic [CNT_W-1:0]   r_rem;
    logic               r_busy;
    logic               r_done;

    logic [CNT_W-1:0]   w_n;
    logic               w_dir;

    // One shift or rotate step; the vacated end gets serial_in or the wrapped bit.
    function automatic logic [WIDTH-1:0] f_step(
        input logic [WIDTH-1:0] q,
        input logic             rot,
        input logic             dir,
        input logic             sin
    );
        logic fill;
        fill = rot ? (dir ? q[0] : q[WIDTH-1]) : sin;
        return dir ? {fill, q[WIDTH-1:1]} : {q[WIDTH-2:0], fill};
    endfunction

    assign w_n   = (count > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : count;
    assign w_dir = (r_state == ST_RUN) ? r_dir : leftright;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_q     <= RESET_VAL;
            r_rot   <= 1'b0;
            r_dir   <= 1'b0;
            r_rem   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            // done is a single-cycle pulse independent of enable
            r_done <= 1'b0;
            if (enable) begin
                case (r_state)
                    ST_IDLE: begin
                        if (start) begin
                            r_rot <= (mode == MODE_ROTATE);
                            r_dir <= leftright;
                            if (w_n == '0) begin
                                r_done <= 1'b1;
                            end else begin
                                r_rem   <= w_n;
                                r_busy  <= 1'b1;
                                r_state <= ST_RUN;
                            end
                        end else begin
                            case (mode)
                                MODE_SHIFT:  r_q <= f_step(r_q, 1'b0, leftright, serial_in);
                                MODE_ROTATE: r_q <= f_step(r_q, 1'b1, leftright, serial_in);
                                MODE_LOAD:   r_q <= par_in;
                                default:     r_q <= r_q;
                            endcase
                        end
                    end
                    ST_RUN: begin
                        r_q   <= f_step(r_q, r_rot, r_dir, serial_in);
                        r_rem <= r_rem - CNT_W'(1);
                        if (r_rem == CNT_W'(1)) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign serial_out = w_dir ? r_q[0] : r_q[WIDTH-1];
    assign par_out    = r_q;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule

// File: tb/tb_serie_universal_shifter.sv
// Directed bench for serie_universal_shifter (WIDTH=8): table of per-cycle ops plus
// hand-written burst, clamp, enable-gap, zero-count and reset sequences.
module tb_serie_universal_shifter;

    logic       clock = 1'b0;
    logic       reset;
    logic       enable;
    logic [1:0] mode;
    logic       leftright;
    logic       serial_in;
    logic [7:0] par_in;
    logic       start;
    logic [3:0] count;
    logic       serial_out;
    logic [7:0] par_out;
    logic       busy;
    logic       done;

    int errors = 0;
    int checks = 0;

    serie_universal_shifter #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .mode       (mode),
        .leftright  (leftright),
        .serial_in  (serial_in),
        .par_in     (par_in),
        .start      (start),
        .count      (count),
        .serial_out (serial_out),
        .par_out    (par_out),
        .busy       (busy),
        .done       (done)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0] mode;
        logic       lr;
        logic       sin;
        logic [7:0] par;
        logic       exp_so;
        logic [7:0] exp_q;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load(input logic [7:0] v);
        mode = 2'b11; par_in = v; start = 1'b0;
        tick();
        mode = 2'b00;
    endtask

    // Observe a fixed window of edges, counting busy cycles and done pulses.
    task automatic tally(input int edges, output int n_busy, output int n_done);
        n_busy = 0;
        n_done = 0;
        for (int i = 0; i < edges; i++) begin
            tick();
            if (busy === 1'b1) n_busy++;
            if (done === 1'b1) n_done++;
        end
    endtask

    int nb;
    int nd;

    initial begin
        vecs[0] = '{2'b11, 1'b0, 1'b0, 8'hA5, 1'b0, 8'hA5};
        vecs[1] = '{2'b01, 1'b0, 1'b1, 8'h00, 1'b1, 8'h4B};
        vecs[2] = '{2'b01, 1'b0, 1'b1, 8'h00, 1'b0, 8'h97};
        vecs[3] = '{2'b01, 1'b0, 1'b1, 8'h00, 1'b1, 8'h2F};
        vecs[4] = '{2'b01, 1'b1, 1'b0, 8'h00, 1'b1, 8'h17};
        vecs[5] = '{2'b10, 1'b0, 1'b1, 8'h00, 1'b0, 8'h2E};
        vecs[6] = '{2'b10, 1'b1, 1'b1, 8'h00, 1'b0, 8'h17};
        vecs[7] = '{2'b00, 1'b1, 1'b0, 8'hFF, 1'b1, 8'h17};
        vecs[8] = '{2'b01, 1'b1, 1'b1, 8'h00, 1'b1, 8'h8B};
        vecs[9] = '{2'b10, 1'b1, 1'b0, 8'h00, 1'b1, 8'hC5};

        reset = 1'b1; enable = 1'b1; mode = 2'b00; leftright = 1'b0;
        serial_in = 1'b0; par_in = 8'h00; start = 1'b0; count = 4'd0;
        #12;
        chk("reset_q", 32'(par_out), 32'h00);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_done", 32'(done), 32'h0);
        reset = 1'b0;
        tick();

        // Free-running per-cycle operations
        for (int i = 0; i < 10; i++) begin
            mode = vecs[i].mode; leftright = vecs[i].lr;
            serial_in = vecs[i].sin; par_in = vecs[i].par;
            #1;
            chk($sformatf("vec%0d_so", i), 32'(serial_out), 32'(vecs[i].exp_so));
            tick();
            chk($sformatf("vec%0d_q", i), 32'(par_out), 32'(vecs[i].exp_q));
        end
        mode = 2'b00;

        // Rotate-right burst of 3 from 81, leftright live at 0 while running
        load(8'h81);
        chk("rot_load", 32'(par_out), 32'h81);
        start = 1'b1; mode = 2'b10; leftright = 1'b1; count = 4'd3;
        tick();
        start = 1'b0; mode = 2'b00; leftright = 1'b0;
        chk("rot_start_busy", 32'(busy), 32'h1);
        chk("rot_start_q", 32'(par_out), 32'h81);
        chk("rot_run_so_latched_dir", 32'(serial_out), 32'h1);
        tick();
        chk("rot_s1_q", 32'(par_out), 32'hC0);
        chk("rot_s1_busy", 32'(busy), 32'h1);
        tick();
        chk("rot_s2_q", 32'(par_out), 32'h60);
        chk("rot_s2_done", 32'(done), 32'h0);
        tick();
        chk("rot_s3_q", 32'(par_out), 32'h30);
        chk("rot_s3_busy", 32'(busy), 32'h0);
        chk("rot_s3_done", 32'(done), 32'h1);
        tick();
        chk("rot_done_clear", 32'(done), 32'h0);
        chk("rot_hold_q", 32'(par_out), 32'h30);

        // Count above WIDTH clamps to 8 steps
        load(8'hFF);
        start = 1'b1; mode = 2'b01; leftright = 1'b0; serial_in = 1'b0; count = 4'd12;
        tick();
        start = 1'b0; mode = 2'b00;
        nb = (busy === 1'b1) ? 1 : 0;
        begin
            int b2, d2;
            tally(20, b2, d2);
            chk("clamp_busy_cycles", 32'(nb + b2), 32'd8);
            chk("clamp_done_pulses", 32'(d2), 32'd1);
        end
        chk("clamp_q", 32'(par_out), 32'h00);

        // Enable gap of two cycles after the first step
        load(8'h81);
        start = 1'b1; mode = 2'b10; leftright = 1'b1; count = 4'd3;
        tick();
        start = 1'b0; mode = 2'b00;
        nb = (busy === 1'b1) ? 1 : 0;
        tick();
        nb += (busy === 1'b1) ? 1 : 0;
        chk("gap_s1_q", 32'(par_out), 32'hC0);
        enable = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            nb += (busy === 1'b1) ? 1 : 0;
            chk($sformatf("gap_hold%0d_q", i), 32'(par_out), 32'hC0);
            chk($sformatf("gap_hold%0d_busy", i), 32'(busy), 32'h1);
        end
        enable = 1'b1;
        begin
            int b2, d2;
            tally(6, b2, d2);
            chk("gap_busy_cycles", 32'(nb + b2), 32'd5);
            chk("gap_done_pulses", 32'(d2), 32'd1);
        end
        chk("gap_final_q", 32'(par_out), 32'h30);

        // Zero count: immediate done, no shift even with mode=shift
        start = 1'b1; mode = 2'b01; serial_in = 1'b1; count = 4'd0;
        tick();
        start = 1'b0; mode = 2'b00;
        chk("zero_done", 32'(done), 32'h1);
        chk("zero_busy", 32'(busy), 32'h0);
        chk("zero_q", 32'(par_out), 32'h30);
        tick();
        chk("zero_done_clear", 32'(done), 32'h0);

        // Start held during RUN is ignored
        load(8'h81);
        start = 1'b1; mode = 2'b10; leftright = 1'b1; count = 4'd3;
        tick();
        nb = (busy === 1'b1) ? 1 : 0;
        tick();
        nb += (busy === 1'b1) ? 1 : 0;
        tick();
        nb += (busy === 1'b1) ? 1 : 0;
        start = 1'b0; mode = 2'b00;
        begin
            int b2, d2;
            tally(10, b2, d2);
            chk("busystart_busy_cycles", 32'(nb + b2), 32'd3);
            chk("busystart_done_pulses", 32'(d2), 32'd1);
        end
        chk("busystart_q", 32'(par_out), 32'h30);

        // Asynchronous reset mid-burst
        load(8'h81);
        start = 1'b1; mode = 2'b10; leftright = 1'b1; count = 4'd3;
        tick();
        start = 1'b0; mode = 2'b00;
        tick();
        chk("rst_pre_q", 32'(par_out), 32'hC0);
        #2 reset = 1'b1;
        #1;
        chk("rst_async_q", 32'(par_out), 32'h00);
        chk("rst_async_busy", 32'(busy), 32'h0);
        chk("rst_async_done", 32'(done), 32'h0);
        tick();
        reset = 1'b0;
        tally(6, nb, nd);
        chk("rst_after_busy", 32'(nb), 32'd0);
        chk("rst_after_done", 32'(nd), 32'd0);
        chk("rst_after_q", 32'(par_out), 32'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
